// File: rtl/fb_pixel_plot_unit.sv
// Warp-wide pixel plot engine: clips lanes, groups lanes that share a framebuffer word,
// and performs one read-modify-write per distinct word.
module fb_pixel_plot_unit #(
    parameter int NUM_LANES = 32,
    parameter int FB_WIDTH  = 64,
    parameter int FB_HEIGHT = 64,
    parameter int BPP       = 1,
    parameter int COORD_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  fb_base,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_mode,
    input  logic [NUM_LANES-1:0]         req_mask,
    input  logic [NUM_LANES*COORD_W-1:0] req_x,
    input  logic [NUM_LANES*COORD_W-1:0] req_y,
    input  logic [NUM_LANES*8-1:0]       req_color,
    output logic                         mem_req_valid,
    input  logic                         mem_req_ready,
    output logic                         mem_req_we,
    output logic [31:0]                  mem_req_addr,
    output logic [31:0]                  mem_req_wdata,
    input  logic                         mem_rsp_valid,
    input  logic [31:0]                  mem_rsp_rdata,
    output logic                         done,
    output logic [15:0]                  clip_count
);

    localparam logic [31:0] FB_W32     = 32'(FB_WIDTH);
    localparam logic [31:0] FB_H32     = 32'(FB_HEIGHT);
    localparam logic [31:0] BPP32      = 32'(BPP);
    localparam logic [31:0] FIELD_ONES = (32'd1 << BPP) - 32'd1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_RD    = 3'd2,
        ST_RWAIT = 3'd3,
        ST_WR    = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t               state_r;
    logic                 req_ready_r;
    logic                 mem_req_valid_r;
    logic                 mem_req_we_r;
    logic [31:0]          mem_req_addr_r;
    logic [31:0]          mem_req_wdata_r;
    logic                 done_r;
    logic [15:0]          clip_count_r;
    logic                 mode_r;
    logic [NUM_LANES-1:0] pending_r;
    logic [NUM_LANES-1:0] group_r;
    logic [31:0]          lane_addr_r  [NUM_LANES];
    logic [4:0]           lane_off_r   [NUM_LANES];
    logic [7:0]           lane_color_r [NUM_LANES];

    logic [NUM_LANES-1:0] in_bounds_s;
    logic [31:0]          lane_pbit_s [NUM_LANES];
    logic [31:0]          lane_addr_s [NUM_LANES];
    logic [4:0]           lane_off_s  [NUM_LANES];
    logic [15:0]          drop_cnt_s;
    logic [16:0]          clip_sum_s;
    logic [15:0]          clip_next_s;
    logic                 any_pending_s;
    logic [31:0]          first_addr_s;
    logic [NUM_LANES-1:0] group_s;
    logic [31:0]          merged_s;

    // A coordinate is on-screen when non-negative and below the given extent
    function automatic logic coord_in_range(input logic [COORD_W-1:0] c, input logic [31:0] limit);
        return !c[COORD_W-1] && (32'(c) < limit);
    endfunction

    function automatic logic [31:0] pixel_bit_index(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
        return ((32'(y) * FB_W32) + 32'(x)) * BPP32;
    endfunction

    // OR mode sets colour bits; replace mode clears the field before inserting
    function automatic logic [31:0] merge_field(input logic [31:0] word, input logic [4:0] off,
                                                input logic [7:0] color, input logic replace);
        logic [31:0] fmask;
        logic [31:0] fval;
        fmask = FIELD_ONES << off;
        fval  = ({24'd0, color} & FIELD_ONES) << off;
        return replace ? ((word & ~fmask) | fval) : (word | fval);
    endfunction

    // Per-lane clip test and word/bit location of each incoming pixel
    always_comb begin
        drop_cnt_s = 16'd0;
        for (int i = 0; i < NUM_LANES; i++) begin
            in_bounds_s[i] = coord_in_range(req_x[i*COORD_W +: COORD_W], FB_W32)
                          && coord_in_range(req_y[i*COORD_W +: COORD_W], FB_H32);
            lane_pbit_s[i] = pixel_bit_index(req_x[i*COORD_W +: COORD_W], req_y[i*COORD_W +: COORD_W]);
            lane_addr_s[i] = fb_base + ((lane_pbit_s[i] >> 5) << 2);
            lane_off_s[i]  = lane_pbit_s[i][4:0];
            drop_cnt_s     = drop_cnt_s + {15'd0, req_mask[i] & ~in_bounds_s[i]};
        end
        clip_sum_s  = {1'b0, clip_count_r} + {1'b0, drop_cnt_s};
        clip_next_s = clip_sum_s[16] ? 16'hFFFF : clip_sum_s[15:0];
    end

    // Lowest pending lane picks the word; every pending lane on that word joins the group
    always_comb begin
        first_addr_s = 32'd0;
        group_s      = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            first_addr_s = pending_r[i] ? lane_addr_r[i] : first_addr_s;
        end
        any_pending_s = |pending_r;
        for (int i = 0; i < NUM_LANES; i++) begin
            group_s[i] = pending_r[i] && (lane_addr_r[i] == first_addr_s);
        end
    end

    // Ascending lane order lets the highest lane win on a shared pixel
    always_comb begin
        merged_s = mem_rsp_rdata;
        for (int i = 0; i < NUM_LANES; i++) begin
            merged_s = group_r[i] ? merge_field(merged_s, lane_off_r[i], lane_color_r[i], mode_r) : merged_s;
        end
    end

    // Control FSM with registered memory-side and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            req_ready_r     <= 1'b1;
            mem_req_valid_r <= 1'b0;
            mem_req_we_r    <= 1'b0;
            mem_req_addr_r  <= 32'd0;
            mem_req_wdata_r <= 32'd0;
            done_r          <= 1'b0;
            clip_count_r    <= 16'd0;
            mode_r          <= 1'b0;
            pending_r       <= '0;
            group_r         <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_addr_r[i]  <= 32'd0;
                lane_off_r[i]   <= 5'd0;
                lane_color_r[i] <= 8'd0;
            end
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_valid && req_ready_r) begin
                        req_ready_r  <= 1'b0;
                        mode_r       <= req_mode;
                        pending_r    <= req_mask & in_bounds_s;
                        clip_count_r <= clip_next_s;
                        for (int i = 0; i < NUM_LANES; i++) begin
                            lane_addr_r[i]  <= lane_addr_s[i];
                            lane_off_r[i]   <= lane_off_s[i];
                            lane_color_r[i] <= req_color[i*8 +: 8];
                        end
                        state_r <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (any_pending_s) begin
                        group_r         <= group_s;
                        mem_req_addr_r  <= first_addr_s;
                        mem_req_we_r    <= 1'b0;
                        mem_req_valid_r <= 1'b1;
                        state_r         <= ST_RD;
                    end else begin
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end
                end
                ST_RD: begin
                    if (mem_req_ready) begin
                        mem_req_valid_r <= 1'b0;
                        state_r         <= ST_RWAIT;
                    end
                end
                ST_RWAIT: begin
                    if (mem_rsp_valid) begin
                        mem_req_wdata_r <= merged_s;
                        mem_req_we_r    <= 1'b1;
                        mem_req_valid_r <= 1'b1;
                        state_r         <= ST_WR;
                    end
                end
                ST_WR: begin
                    if (mem_req_ready) begin
                        mem_req_valid_r <= 1'b0;
                        pending_r       <= pending_r & ~group_r;
                        state_r         <= ST_SCAN;
                    end
                end
                ST_DONE: begin
                    req_ready_r <= 1'b1;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    req_ready_r     <= 1'b1;
                    mem_req_valid_r <= 1'b0;
                    state_r         <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready     = req_ready_r;
    assign mem_req_valid = mem_req_valid_r;
    assign mem_req_we    = mem_req_we_r;
    assign mem_req_addr  = mem_req_addr_r;
    assign mem_req_wdata = mem_req_wdata_r;
    assign done          = done_r;
    assign clip_count    = clip_count_r;

endmodule

// File: tb/tb_fb_pixel_plot_unit.sv
// Bench for fb_pixel_plot_unit: a 1bpp and a 4bpp instance share one request stream; each has its
// own memory responder and a pixel-level framebuffer reference model.
module tb_fb_pixel_plot_unit;

    localparam int NL = 32;
    localparam int CW = 16;
    localparam int W  = 64;
    localparam int H  = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [31:0]          fb_base;
    logic                 req_valid;
    logic                 req_mode;
    logic [NL-1:0]        req_mask;
    logic [NL*CW-1:0]     req_x;
    logic [NL*CW-1:0]     req_y;
    logic [NL*8-1:0]      req_color;
    logic [1:0]           req_ready, mrv, mrr, mwe, rspv, done;
    logic [1:0][31:0]     maddr, mwdata, rspd;
    logic [1:0][15:0]     clip_count;

    fb_pixel_plot_unit #(.NUM_LANES(NL), .FB_WIDTH(W), .FB_HEIGHT(H), .BPP(1), .COORD_W(CW)) u_dut0 (
        .clk(clk), .rst(rst), .fb_base(fb_base), .req_valid(req_valid), .req_ready(req_ready[0]),
        .req_mode(req_mode), .req_mask(req_mask), .req_x(req_x), .req_y(req_y), .req_color(req_color),
        .mem_req_valid(mrv[0]), .mem_req_ready(mrr[0]), .mem_req_we(mwe[0]), .mem_req_addr(maddr[0]),
        .mem_req_wdata(mwdata[0]), .mem_rsp_valid(rspv[0]), .mem_rsp_rdata(rspd[0]),
        .done(done[0]), .clip_count(clip_count[0]));

    fb_pixel_plot_unit #(.NUM_LANES(NL), .FB_WIDTH(W), .FB_HEIGHT(H), .BPP(4), .COORD_W(CW)) u_dut1 (
        .clk(clk), .rst(rst), .fb_base(fb_base), .req_valid(req_valid), .req_ready(req_ready[1]),
        .req_mode(req_mode), .req_mask(req_mask), .req_x(req_x), .req_y(req_y), .req_color(req_color),
        .mem_req_valid(mrv[1]), .mem_req_ready(mrr[1]), .mem_req_we(mwe[1]), .mem_req_addr(maddr[1]),
        .mem_req_wdata(mwdata[1]), .mem_rsp_valid(rspv[1]), .mem_rsp_rdata(rspd[1]),
        .done(done[1]), .clip_count(clip_count[1]));

    // Reference pixel values (written by the stimulus process only)
    int pix [2][H][W];
    int model_clip [2];
    int exp_words [2];
    int load_gen = 1;
    int stall_until = 0;
    int rsp_dly_min = 1;
    int rsp_dly_max = 1;
    bit rand_ready = 1'b0;

    // Memory responder state (written by the responder only)
    logic [31:0] mem [2][512];
    int seen_gen = 0;
    int cyc = 0;
    int rd_cnt [2] = '{0, 0};
    int wr_cnt [2] = '{0, 0};
    int done_cnt [2] = '{0, 0};
    int proto_err [2] = '{0, 0};
    int rsp_cnt [2] = '{0, 0};
    int rsp_idx [2] = '{0, 0};
    logic [31:0] last_wr_addr [2];
    logic [31:0] last_wr_data [2];
    logic [1:0] prev_pend = 2'b00;
    logic [1:0] prev_we = 2'b00;
    logic [1:0][31:0] prev_addr, prev_wdata;
    logic prev_rst = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    function automatic int bpp_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic int words_of(input int d);
        return W * H * bpp_of(d) / 32;
    endfunction

    // Packs pixels LSB-first into framebuffer word w
    function automatic logic [31:0] pack_word(input int d, input int w);
        int bpp, ppw, pi;
        logic [31:0] word;
        bpp = bpp_of(d);
        ppw = 32 / bpp;
        word = 32'd0;
        for (int k = 0; k < ppw; k++) begin
            pi = w * ppw + k;
            word = word | (32'(pix[d][pi / W][pi % W] & ((1 << bpp) - 1)) << (k * bpp));
        end
        return word;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory responder: decides ready and response data between clock edges
    always @(negedge clk) begin : mem_model
        logic [31:0] off_v;
        logic rdy_v;
        cyc++;
        if (load_gen != seen_gen) begin
            for (int d = 0; d < 2; d++)
                for (int w = 0; w < words_of(d); w++) mem[d][w] = pack_word(d, w);
            seen_gen = load_gen;
        end
        for (int d = 0; d < 2; d++) begin
            if (done[d]) done_cnt[d]++;
            if (prev_pend[d] && !rst && !prev_rst) begin
                if (!mrv[d] || maddr[d] !== prev_addr[d] || mwe[d] !== prev_we[d] || mwdata[d] !== prev_wdata[d])
                    proto_err[d]++;
            end
            rdy_v = (cyc < stall_until) ? 1'b0 : (rand_ready ? ($urandom_range(3) != 0) : 1'b1);
            mrr[d] = rdy_v;
            rspv[d] = 1'b0;
            if (rsp_cnt[d] > 0) begin
                rsp_cnt[d]--;
                if (rsp_cnt[d] == 0) begin
                    rspv[d] = 1'b1;
                    rspd[d] = mem[d][rsp_idx[d]];
                end
            end
            if (mrv[d] && rdy_v && !rst) begin
                off_v = maddr[d] - fb_base;
                if (off_v[1:0] != 2'b00 || (off_v >> 2) >= 32'(words_of(d))) begin
                    proto_err[d]++;
                end else if (mwe[d]) begin
                    mem[d][off_v >> 2] = mwdata[d];
                    wr_cnt[d]++;
                    last_wr_addr[d] = maddr[d];
                    last_wr_data[d] = mwdata[d];
                end else begin
                    if (rsp_cnt[d] > 0) proto_err[d]++;
                    rsp_idx[d] = int'(off_v >> 2);
                    rsp_cnt[d] = int'($urandom_range(rsp_dly_max, rsp_dly_min));
                    rd_cnt[d]++;
                end
            end
            prev_pend[d]  = mrv[d] && !rdy_v;
            prev_we[d]    = mwe[d];
            prev_addr[d]  = maddr[d];
            prev_wdata[d] = mwdata[d];
        end
        prev_rst = rst;
    end

    task automatic clear_lanes();
        req_mask = '0;
        req_x = '0;
        req_y = '0;
        req_color = '0;
    endtask

    task automatic set_lane(input int i, input int x, input int y, input int c);
        req_mask[i] = 1'b1;
        req_x[i*CW +: CW] = 16'(x);
        req_y[i*CW +: CW] = 16'(y);
        req_color[i*8 +: 8] = 8'(c);
    endtask

    // Applies the request to the pixel model and counts expected distinct words and clips
    task automatic apply_model();
        int x, y, c, clipped;
        bit seen [int];
        for (int d = 0; d < 2; d++) begin
            clipped = 0;
            seen.delete();
            for (int i = 0; i < NL; i++) begin
                if (req_mask[i]) begin
                    x = int'($signed(req_x[i*CW +: CW]));
                    y = int'($signed(req_y[i*CW +: CW]));
                    if (x < 0 || y < 0 || x >= W || y >= H) begin
                        clipped++;
                    end else begin
                        c = int'(req_color[i*8 +: 8]) & ((1 << bpp_of(d)) - 1);
                        pix[d][y][x] = req_mode ? c : (pix[d][y][x] | c);
                        seen[(y * W + x) * bpp_of(d) / 32] = 1'b1;
                    end
                end
            end
            exp_words[d] = seen.num();
            model_clip[d] = (model_clip[d] + clipped > 65535) ? 65535 : model_clip[d] + clipped;
        end
    endtask

    task automatic do_request(input string tag);
        int brd [2], bwr [2], bdn [2];
        int n;
        check_eq({tag, "_ready_in"}, 32'(req_ready), 32'd3);
        apply_model();
        for (int d = 0; d < 2; d++) begin
            brd[d] = rd_cnt[d];
            bwr[d] = wr_cnt[d];
            bdn[d] = done_cnt[d];
        end
        @(posedge clk); #1 req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        n = 0;
        while (!(done_cnt[0] > bdn[0] && done_cnt[1] > bdn[1]) && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq({tag, "_done_in_time"}, 32'(n < 5000), 32'd1);
        repeat (2) begin
            @(posedge clk); #1;
        end
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("%s_d%0d_done_pulses", tag, d), done_cnt[d] - bdn[d], 32'd1);
            check_eq($sformatf("%s_d%0d_reads", tag, d), rd_cnt[d] - brd[d], exp_words[d]);
            check_eq($sformatf("%s_d%0d_writes", tag, d), wr_cnt[d] - bwr[d], exp_words[d]);
            check_eq($sformatf("%s_d%0d_clip_count", tag, d), 32'(clip_count[d]), model_clip[d]);
            check_eq($sformatf("%s_d%0d_ready_after", tag, d), 32'(req_ready[d]), 32'd1);
            for (int w = 0; w < words_of(d); w++)
                check_eq($sformatf("%s_d%0d_mem_w%0d", tag, d, w), mem[d][w], pack_word(d, w));
        end
    endtask

    task automatic reload_memory();
        load_gen++;
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin : stim
        int bwr0, bwr1, brd0, brd1, n, r;
        rst = 1'b1;
        req_valid = 1'b0;
        req_mode = 1'b0;
        clear_lanes();
        fb_base = 32'h4000_0000 + ($urandom_range(255) << 12);
        model_clip[0] = 0;
        model_clip[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("rst_d%0d_req_ready", d), 32'(req_ready[d]), 32'd1);
            check_eq($sformatf("rst_d%0d_mem_valid", d), 32'(mrv[d]), 32'd0);
            check_eq($sformatf("rst_d%0d_mem_we", d), 32'(mwe[d]), 32'd0);
            check_eq($sformatf("rst_d%0d_addr", d), maddr[d], 32'd0);
            check_eq($sformatf("rst_d%0d_wdata", d), mwdata[d], 32'd0);
            check_eq($sformatf("rst_d%0d_done", d), 32'(done[d]), 32'd0);
            check_eq($sformatf("rst_d%0d_clip", d), 32'(clip_count[d]), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        clear_lanes(); req_mode = 1'b0; set_lane(0, 5, 3, 1);
        do_request("single");
        check_eq("single_d0_addr", last_wr_addr[0], fb_base + 32'h18);
        check_eq("single_d0_data", last_wr_data[0], 32'h0000_0020);
        check_eq("single_d1_addr", last_wr_addr[1], fb_base + 32'h60);
        check_eq("single_d1_data", last_wr_data[1], 32'h0010_0000);

        clear_lanes();
        for (int i = 0; i < 8; i++) set_lane(i, i, 0, 1);
        do_request("coalesce");
        check_eq("coalesce_d0_data", last_wr_data[0], 32'h0000_00FF);
        check_eq("coalesce_d1_data", last_wr_data[1], 32'h1111_1111);

        clear_lanes();
        set_lane(0, -1, 0, 1); set_lane(1, 64, 0, 1); set_lane(2, 0, 64, 1); set_lane(3, 1, 1, 1);
        do_request("clip");
        check_eq("clip_d0_count", 32'(clip_count[0]), 32'd3);
        check_eq("clip_d0_addr", last_wr_addr[0], fb_base + 32'h8);
        check_eq("clip_d0_data", last_wr_data[0], 32'h0000_0002);

        for (int x = 0; x < 8; x++) pix[1][0][x] = 15;
        reload_memory();
        clear_lanes(); req_mode = 1'b1; set_lane(2, 0, 0, 8'h3); set_lane(9, 0, 0, 8'hA);
        do_request("replace");
        check_eq("replace_d1_data", last_wr_data[1], 32'hFFFF_FFFA);
        check_eq("replace_d0_data", last_wr_data[0], 32'h0000_00FE);

        clear_lanes(); req_mode = 1'b0;
        do_request("empty");

        clear_lanes(); set_lane(0, 20, 20, 1);
        rsp_dly_min = 7; rsp_dly_max = 7;
        stall_until = cyc + 14;
        do_request("stall");
        check_eq("stall_d0_proto", proto_err[0], 32'd0);
        check_eq("stall_d1_proto", proto_err[1], 32'd0);

        // Reset while both units wait for read data; the late response must be ignored
        clear_lanes(); set_lane(0, 10, 10, 1);
        rsp_dly_min = 20; rsp_dly_max = 20;
        brd0 = rd_cnt[0]; brd1 = rd_cnt[1]; bwr0 = wr_cnt[0]; bwr1 = wr_cnt[1];
        @(posedge clk); #1 req_valid = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0;
        n = 0;
        while (!(rd_cnt[0] > brd0 && rd_cnt[1] > brd1) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("rstmid_read_seen", 32'(n < 200), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        model_clip[0] = 0; model_clip[1] = 0;
        repeat (30) begin
            @(posedge clk); #1;
        end
        check_eq("rstmid_d0_no_write", wr_cnt[0], bwr0);
        check_eq("rstmid_d1_no_write", wr_cnt[1], bwr1);
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("rstmid_d%0d_ready", d), 32'(req_ready[d]), 32'd1);
            check_eq($sformatf("rstmid_d%0d_mem_valid", d), 32'(mrv[d]), 32'd0);
            check_eq($sformatf("rstmid_d%0d_clip", d), 32'(clip_count[d]), 32'd0);
        end

        for (int d = 0; d < 2; d++)
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++) pix[d][y][x] = int'($urandom_range((1 << bpp_of(d)) - 1));
        reload_memory();
        rand_ready = 1'b1;
        rsp_dly_min = 1; rsp_dly_max = 4;
        for (int t = 0; t < 25; t++) begin
            clear_lanes();
            req_mode = 1'($urandom_range(1));
            r = int'($urandom_range(2));
            for (int i = 0; i < NL; i++) begin
                if ($urandom_range(3) != 0) begin
                    if (r == 0) set_lane(i, int'($urandom_range(15)), int'($urandom_range(1)), int'($urandom_range(255)));
                    else set_lane(i, int'($urandom_range(79)) - 8, int'($urandom_range(79)) - 8, int'($urandom_range(255)));
                end
            end
            do_request($sformatf("rand%0d", t));
        end
        check_eq("final_d0_proto", proto_err[0], 32'd0);
        check_eq("final_d1_proto", proto_err[1], 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule
